// File: rtl/pac_move_ctrl_if.sv
// Signal bundle between the Pac-Man movement controller and the game side
// (key inputs, maze wall flags, game_over, and the move / start pulses back).
// Handshake: there is no valid/ready here. Keys, walls and game_over are levels
// sampled on rising clk; m_*, e_start are one-cycle pulses that the datapath
// must act on in the cycle they are high; running is a level.
interface pac_move_ctrl_if;
   logic key_up;
   logic key_down;
   logic key_left;
   logic key_right;
   logic wall_up;
   logic wall_down;
   logic wall_left;
   logic wall_right;
   logic game_over;
   logic m_up;
   logic m_down;
   logic m_left;
   logic m_right;
   logic e_start;
   logic running;

   // Game / datapath side
   modport master (
      output key_up, key_down, key_left, key_right,
      output wall_up, wall_down, wall_left, wall_right,
      output game_over,
      input  m_up, m_down, m_left, m_right, e_start, running
   );

   // Movement controller side
   modport slave (
      input  key_up, key_down, key_left, key_right,
      input  wall_up, wall_down, wall_left, wall_right,
      input  game_over,
      output m_up, m_down, m_left, m_right, e_start, running
   );
endinterface

// File: rtl/pac_move_ctrl.sv
// Pac-Man movement controller: IDLE -> START -> RUN FSM, a move-rate tick
// counter, a current direction and a sticky queued direction. Every
// MOVE_DIV cycles in RUN it issues at most one registered move pulse,
// preferring the queued turn and falling back to the current heading.
module pac_move_ctrl #(
   parameter int MOVE_DIV = 5000000
) (
   input  logic                 clk,
   input  logic                 reset,
   pac_move_ctrl_if.slave       bus,
   output logic [1:0]           o_dbg_state
);

   localparam int CW = $clog2(MOVE_DIV);
   localparam logic [CW-1:0] TICK_MAX = CW'(MOVE_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      D_UP    = 2'd0,
      D_DOWN  = 2'd1,
      D_LEFT  = 2'd2,
      D_RIGHT = 2'd3
   } dir_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   dir_t            r_cur_dir;
   logic            r_cur_vld;
   dir_t            r_q_dir;
   logic            r_q_vld;
   logic            r_m_up;
   logic            r_m_down;
   logic            r_m_left;
   logic            r_m_right;
   logic            r_e_start;
   logic            r_running;

   logic            w_key_any;
   dir_t            w_key_dir;
   logic [3:0]      w_walls;
   logic            w_tick;
   logic            w_mv_en;
   dir_t            w_mv_dir;
   logic            w_adopt;

   // Walls indexed by direction code so a dir can select its own flag
   assign w_walls   = {bus.wall_right, bus.wall_left, bus.wall_down, bus.wall_up};
   assign w_key_any = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
   // game_over wins over a tick landing in the same cycle
   assign w_tick    = (r_state == S_RUN) && !bus.game_over && (r_cnt == TICK_MAX);

   // Highest-priority pressed key: up > down > left > right
   always_comb begin
      w_key_dir = D_UP;
      if (bus.key_up)         w_key_dir = D_UP;
      else if (bus.key_down)  w_key_dir = D_DOWN;
      else if (bus.key_left)  w_key_dir = D_LEFT;
      else if (bus.key_right) w_key_dir = D_RIGHT;
   end

   // Move decision at a tick: queued turn first, else keep current heading
   always_comb begin
      w_mv_en  = 1'b0;
      w_mv_dir = r_cur_dir;
      w_adopt  = 1'b0;
      if (w_tick) begin
         if (r_q_vld && !w_walls[r_q_dir]) begin
            w_mv_en  = 1'b1;
            w_mv_dir = r_q_dir;
            w_adopt  = 1'b1;
         end else if (r_cur_vld && !w_walls[r_cur_dir]) begin
            w_mv_en  = 1'b1;
            w_mv_dir = r_cur_dir;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_key_any) w_next = S_START;
         S_START: w_next = S_RUN;
         S_RUN:   if (bus.game_over) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Tick counter: runs only while staying in RUN, otherwise parked at 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state == S_RUN && !bus.game_over) begin
         r_cnt <= (r_cnt == TICK_MAX) ? '0 : r_cnt + CW'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // Direction registers. IDLE keeps the heading cleared and tracks the keys
   // so the press that starts the game is already queued on entry to START.
   // A press on the tick edge overwrites the queue after the adoption clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cur_dir <= D_UP;
         r_cur_vld <= 1'b0;
         r_q_dir   <= D_UP;
         r_q_vld   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cur_vld <= 1'b0;
               r_q_vld   <= w_key_any;
               r_q_dir   <= w_key_dir;
            end
            S_START: begin
               r_cur_vld <= 1'b0;
               if (w_key_any) begin
                  r_q_vld <= 1'b1;
                  r_q_dir <= w_key_dir;
               end
            end
            S_RUN: begin
               if (w_adopt) begin
                  r_cur_dir <= r_q_dir;
                  r_cur_vld <= 1'b1;
                  r_q_vld   <= 1'b0;
               end
               if (w_key_any) begin
                  r_q_vld <= 1'b1;
                  r_q_dir <= w_key_dir;
               end
            end
            default: begin
               r_cur_vld <= 1'b0;
               r_q_vld   <= 1'b0;
            end
         endcase
      end
   end

   // Registered outputs: one-hot move pulse, start pulse, running level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_up    <= 1'b0;
         r_m_down  <= 1'b0;
         r_m_left  <= 1'b0;
         r_m_right <= 1'b0;
         r_e_start <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_m_up    <= w_mv_en && (w_mv_dir == D_UP);
         r_m_down  <= w_mv_en && (w_mv_dir == D_DOWN);
         r_m_left  <= w_mv_en && (w_mv_dir == D_LEFT);
         r_m_right <= w_mv_en && (w_mv_dir == D_RIGHT);
         r_e_start <= (w_next == S_START);
         r_running <= (w_next == S_RUN);
      end
   end

   assign bus.m_up    = r_m_up;
   assign bus.m_down  = r_m_down;
   assign bus.m_left  = r_m_left;
   assign bus.m_right = r_m_right;
   assign bus.e_start = r_e_start;
   assign bus.running = r_running;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Directed bench for pac_move_ctrl with MOVE_DIV = 4. Inputs change and
// outputs are checked on the falling clock edge.
module tb_pac_move_ctrl;

   localparam logic [3:0] MV_0 = 4'b0000;
   localparam logic [3:0] MV_U = 4'b1000;
   localparam logic [3:0] MV_D = 4'b0100;
   localparam logic [3:0] MV_L = 4'b0010;
   localparam logic [3:0] MV_R = 4'b0001;
   localparam logic [7:0] ST_IDLE  = 8'd0;
   localparam logic [7:0] ST_START = 8'd1;
   localparam logic [7:0] ST_RUN   = 8'd2;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         n_vec;
   int         n_err;

   pac_move_ctrl_if bus ();

   pac_move_ctrl #(.MOVE_DIV(4)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] moves();
      return {bus.m_up, bus.m_down, bus.m_left, bus.m_right};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Step n falling edges; moves must be idle except exp on the last one
   task automatic run_expect(input string tag, input int n, input logic [3:0] exp);
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         check(tag, {4'b0, moves()}, (i == n) ? {4'b0, exp} : 8'h00);
      end
   endtask

   task automatic set_walls(input logic [3:0] w);
      {bus.wall_up, bus.wall_down, bus.wall_left, bus.wall_right} = w;
   endtask

   task automatic set_keys(input logic [3:0] k);
      {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1;
      set_keys(4'b0000);
      set_walls(4'b0000);
      bus.game_over = 1'b0;
      #1 rst_n = 1'b0;

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      check("rst_moves",   {4'b0, moves()}, 8'h00);
      check("rst_estart",  {7'b0, bus.e_start}, 8'h00);
      check("rst_running", {7'b0, bus.running}, 8'h00);
      check("rst_state",   {6'b0, dbg_state}, ST_IDLE);
      rst_n = 1'b1;

      // No keys: stays idle
      repeat (3) @(negedge clk);
      check("idle_state",   {6'b0, dbg_state}, ST_IDLE);
      check("idle_estart",  {7'b0, bus.e_start}, 8'h00);
      check("idle_running", {7'b0, bus.running}, 8'h00);
      check("idle_moves",   {4'b0, moves()}, 8'h00);

      // key_right for one cycle starts the game
      set_keys(MV_R);
      @(negedge clk);
      check("start_estart",  {7'b0, bus.e_start}, 8'h01);
      check("start_state",   {6'b0, dbg_state}, ST_START);
      check("start_running", {7'b0, bus.running}, 8'h00);
      set_keys(4'b0000);
      @(negedge clk);
      check("run_running", {7'b0, bus.running}, 8'h01);
      check("run_estart",  {7'b0, bus.e_start}, 8'h00);
      check("run_state",   {6'b0, dbg_state}, ST_RUN);
      check("run_moves0",  {4'b0, moves()}, 8'h00);
      run_expect("first_right", 4, MV_R);
      run_expect("second_right", 4, MV_R);

      // key_up pulsed while up is walled: heading right continues
      set_walls(MV_U);
      set_keys(MV_U);
      run_expect("upkey_cycle", 1, MV_0);
      set_keys(4'b0000);
      run_expect("blocked_up_r1", 3, MV_R);
      run_expect("blocked_up_r2", 4, MV_R);
      set_walls(4'b0000);
      run_expect("turn_up", 4, MV_U);
      run_expect("keep_up", 4, MV_U);

      // down + left together: down wins (also a reversal)
      set_keys(MV_D | MV_L);
      run_expect("dl_cycle", 1, MV_0);
      set_keys(4'b0000);
      run_expect("prio_down", 3, MV_D);
      // up + left together: up wins (reversal back)
      set_keys(MV_U | MV_L);
      run_expect("ul_cycle", 1, MV_0);
      set_keys(4'b0000);
      run_expect("prio_up", 3, MV_U);

      // All walls: stationary; a queued left survives until unblocked
      set_walls(4'b1111);
      run_expect("walled_1", 4, MV_0);
      set_keys(MV_L);
      run_expect("walled_key", 1, MV_0);
      set_keys(4'b0000);
      run_expect("walled_2", 3, MV_0);
      set_walls(4'b0000);
      run_expect("unblock_left", 4, MV_L);

      // game_over during the tick cycle: no pulse, back to idle
      run_expect("pre_go", 3, MV_0);
      bus.game_over = 1'b1;
      @(negedge clk);
      check("go_moves",   {4'b0, moves()}, 8'h00);
      check("go_running", {7'b0, bus.running}, 8'h00);
      check("go_state",   {6'b0, dbg_state}, ST_IDLE);
      bus.game_over = 1'b0;
      repeat (2) @(negedge clk);
      check("go_idle_hold", {6'b0, dbg_state}, ST_IDLE);

      // Restart; game_over during START is ignored
      set_keys(MV_L);
      @(negedge clk);
      check("restart_estart", {7'b0, bus.e_start}, 8'h01);
      set_keys(4'b0000);
      bus.game_over = 1'b1;
      @(negedge clk);
      check("restart_state",   {6'b0, dbg_state}, ST_RUN);
      check("restart_running", {7'b0, bus.running}, 8'h01);
      bus.game_over = 1'b0;

      // Key on the tick edge: tick uses old queue, new key used next tick
      run_expect("pre_tick", 3, MV_0);
      set_keys(MV_R);
      run_expect("tick_edge_left", 1, MV_L);
      set_keys(4'b0000);
      run_expect("pre_pulse", 3, MV_0);

      // Reset while the move pulse is high: everything drops at once
      @(posedge clk);
      #1;
      check("pulse_before_rst", {4'b0, moves()}, {4'b0, MV_R});
      rst_n = 1'b0;
      #1;
      check("async_moves",   {4'b0, moves()}, 8'h00);
      check("async_running", {7'b0, bus.running}, 8'h00);
      check("async_state",   {6'b0, dbg_state}, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_state", {6'b0, dbg_state}, ST_IDLE);
      check("post_rst_moves", {4'b0, moves()}, 8'h00);

      // Restart after reset: counter was cleared, first move after 4 cycles
      set_keys(MV_D);
      @(negedge clk);
      check("rst_restart_estart", {7'b0, bus.e_start}, 8'h01);
      set_keys(4'b0000);
      @(negedge clk);
      check("rst_restart_running", {7'b0, bus.running}, 8'h01);
      run_expect("rst_restart_down", 4, MV_D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
